// File: rtl/stack_mon.sv
// Zero-latency monitor in front of the data/return stack: tracks occupancy, flags over/underflow, exposes status via IO.
// Optional STACK_MON_TRAP_EN suppresses the violating stack move (delta_out forced to 00).
module stack_mon #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic [1:0]       delta_in,
   input  logic             we_in,
   input  logic [WIDTH-1:0] wd_in,
   output logic [1:0]       delta_out,
   output logic             we_out,
   output logic [WIDTH-1:0] wd_out,
   input  logic             io_sel,
   input  logic [1:0]       io_addr,
   input  logic             io_wr,
   input  logic [WIDTH-1:0] io_din,
   output logic [WIDTH-1:0] io_dout,
   output logic             trap
);

   localparam int DW = $clog2(DEPTH + 2);
   localparam logic [DW-1:0] FULL = DW'(DEPTH + 1);
   localparam logic [CW-1:0] VMAX = '1;

   logic [DW-1:0] r_depth;
   logic [DW-1:0] r_hwm;
   logic [CW-1:0] r_vcnt;
   logic          r_ovf;
   logic          r_unf;
   logic          r_trap;

   logic          w_push;
   logic          w_pop;
   logic          w_ovf_ev;
   logic          w_unf_ev;
   logic          w_viol;
   logic          w_io_we;
   logic          w_wr_stat;
   logic          w_wr_hwm;
   logic          w_wr_vcnt;
   logic [DW-1:0] w_depth_next;
   logic [DW-1:0] w_hwm_next;
   logic [CW-1:0] w_vcnt_next;
   logic          w_ovf_next;
   logic          w_unf_next;
   logic          w_unused_din;

   assign w_push    = (delta_in == 2'b01);
   assign w_pop     = (delta_in == 2'b11);
   assign w_ovf_ev  = w_push && (r_depth == FULL);
   assign w_unf_ev  = w_pop && (r_depth == '0);
   assign w_viol    = w_ovf_ev | w_unf_ev;

   assign w_io_we   = io_sel & io_wr;
   assign w_wr_stat = w_io_we && (io_addr == 2'd0);
   assign w_wr_hwm  = w_io_we && (io_addr == 2'd1);
   assign w_wr_vcnt = w_io_we && (io_addr == 2'd2);

   // Only the two flag bits of a status write carry meaning.
   assign w_unused_din = ^io_din[WIDTH-3:0];

   assign we_out = we_in;
   assign wd_out = wd_in;

`ifdef STACK_MON_TRAP_EN
   assign delta_out = w_viol ? 2'b00 : delta_in;
`else
   assign delta_out = delta_in;
`endif

   assign trap = r_trap;

   always_comb begin
      w_depth_next = r_depth;
      if (w_push && !w_ovf_ev) begin
         w_depth_next = r_depth + DW'(1);
      end else if (w_pop && !w_unf_ev) begin
         w_depth_next = r_depth - DW'(1);
      end
   end

   // A violation in the same cycle as a firmware clear wins over the clear.
   always_comb begin
      w_ovf_next = w_ovf_ev | (r_ovf & ~(w_wr_stat & io_din[WIDTH-1]));
      w_unf_next = w_unf_ev | (r_unf & ~(w_wr_stat & io_din[WIDTH-2]));

      w_vcnt_next = r_vcnt;
      if (w_wr_vcnt) begin
         w_vcnt_next = '0;
      end
      if (w_viol && (w_vcnt_next != VMAX)) begin
         w_vcnt_next = w_vcnt_next + CW'(1);
      end

      w_hwm_next = r_hwm;
      if (w_wr_hwm || (w_depth_next > r_hwm)) begin
         w_hwm_next = w_depth_next;
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_depth <= '0;
         r_hwm   <= '0;
         r_vcnt  <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_trap  <= 1'b0;
      end else begin
         r_depth <= w_depth_next;
         r_hwm   <= w_hwm_next;
         r_vcnt  <= w_vcnt_next;
         r_ovf   <= w_ovf_next;
         r_unf   <= w_unf_next;
         r_trap  <= w_viol;
      end
   end

   always_comb begin
      io_dout = '0;
      if (io_sel) begin
         case (io_addr)
            2'd0:    io_dout = {r_ovf, r_unf, {(WIDTH-2-DW){1'b0}}, r_depth};
            2'd1:    io_dout = {{(WIDTH-DW){1'b0}}, r_hwm};
            2'd2:    io_dout = {{(WIDTH-CW){1'b0}}, r_vcnt};
            default: io_dout = WIDTH'(DEPTH + 1);
         endcase
      end
   end

endmodule

// File: tb/tb_stack_mon.sv
// Self-checking bench for stack_mon: vector table, hand-written corner sequences and a random walk
// compared against a plain-integer occupancy model.
module tb_stack_mon;

   localparam int DEPTH = 16;
   localparam int WIDTH = 16;
   localparam int CW    = 8;
   localparam int FULL  = DEPTH + 1;
   localparam int VMAX  = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             resetq;
   logic [1:0]       delta_in;
   logic             we_in;
   logic [WIDTH-1:0] wd_in;
   logic [1:0]       delta_out;
   logic             we_out;
   logic [WIDTH-1:0] wd_out;
   logic             io_sel;
   logic [1:0]       io_addr;
   logic             io_wr;
   logic [WIDTH-1:0] io_din;
   logic [WIDTH-1:0] io_dout;
   logic             trap;

   stack_mon #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
      .clk(clk), .resetq(resetq),
      .delta_in(delta_in), .we_in(we_in), .wd_in(wd_in),
      .delta_out(delta_out), .we_out(we_out), .wd_out(wd_out),
      .io_sel(io_sel), .io_addr(io_addr), .io_wr(io_wr), .io_din(io_din),
      .io_dout(io_dout), .trap(trap)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFail   = 0;

   // Reference model: occupancy as a plain integer, flags as bits.
   int mDepth, mHwm, mVcnt;
   bit mOvf, mUnf, mTrap;

   typedef struct {
      logic [1:0]  d;
      logic        we;
      logic [15:0] wd;
      logic        wr;
      logic [1:0]  wa;
      logic [15:0] wdat;
      logic [1:0]  ra;
      logic [15:0] expRd;
      logic        expTrap;
   } vec_t;

   vec_t vecs[15];

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      mDepth = 0; mHwm = 0; mVcnt = 0;
      mOvf = 0; mUnf = 0; mTrap = 0;
   endtask

   function automatic logic [15:0] expRead(input logic sel, input logic [1:0] addr);
      logic [15:0] r;
      r = '0;
      if (sel) begin
         case (addr)
            2'd0: begin r[15] = mOvf; r[14] = mUnf; r[4:0] = 5'(mDepth); end
            2'd1: r = 16'(mHwm);
            2'd2: r = 16'(mVcnt);
            default: r = 16'(FULL);
         endcase
      end
      return r;
   endfunction

   task automatic idleInputs();
      delta_in = 2'b00; we_in = 1'b0; wd_in = '0;
      io_sel = 1'b0; io_addr = 2'd0; io_wr = 1'b0; io_din = '0;
   endtask

   // One clock cycle: drive at negedge, check combinational paths, advance model at posedge, check trap.
   task automatic applyStimulus(input logic [1:0] d, input logic we, input logic [15:0] wd,
                                input logic sel, input logic [1:0] addr, input logic wr,
                                input logic [15:0] din);
      bit ovfEv, unfEv, isPush, isPop;
      logic [1:0] expD;
      int nd;
      @(negedge clk);
      delta_in = d; we_in = we; wd_in = wd;
      io_sel = sel; io_addr = addr; io_wr = wr; io_din = din;
      #1;
      isPush = (d == 2'b01);
      isPop  = (d == 2'b11);
      ovfEv  = isPush && (mDepth == FULL);
      unfEv  = isPop && (mDepth == 0);
      expD   = d;
`ifdef STACK_MON_TRAP_EN
      if (ovfEv || unfEv) expD = 2'b00;
`endif
      checkOutput("delta_out", 16'(delta_out), 16'(expD));
      checkOutput("we_out", 16'(we_out), 16'(we));
      checkOutput("wd_out", wd_out, wd);
      checkOutput("io_dout", io_dout, expRead(sel, addr));
      @(posedge clk);
      if (sel && wr && addr == 2'd0) begin
         if (din[15]) mOvf = 0;
         if (din[14]) mUnf = 0;
      end
      if (ovfEv) mOvf = 1;
      if (unfEv) mUnf = 1;
      if (sel && wr && addr == 2'd2) mVcnt = 0;
      if ((ovfEv || unfEv) && mVcnt < VMAX) mVcnt++;
      nd = mDepth + ((isPush && !ovfEv) ? 1 : 0) - ((isPop && !unfEv) ? 1 : 0);
      if ((sel && wr && addr == 2'd1) || nd > mHwm) mHwm = nd;
      mDepth = nd;
      mTrap  = ovfEv || unfEv;
      #1;
      checkOutput("trap", 16'(trap), 16'(mTrap));
      idleInputs();
   endtask

   task automatic readReg(input logic [1:0] addr, input logic [15:0] expected, input string name);
      delta_in = 2'b00; we_in = 1'b0; io_wr = 1'b0;
      io_sel = 1'b1; io_addr = addr;
      #1;
      checkOutput(name, io_dout, expected);
      io_sel = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      resetq = 1'b0;
      modelReset();
      @(negedge clk);
      resetq = 1'b1;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) applyStimulus(2'b01, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 16'h0);
   endtask

   task automatic pop(input int n);
      for (int i = 0; i < n; i++) applyStimulus(2'b11, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 16'h0);
   endtask

   task automatic ioWrite(input logic [1:0] addr, input logic [15:0] din);
      applyStimulus(2'b00, 1'b0, 16'h0, 1'b1, addr, 1'b1, din);
   endtask

   initial begin
      resetq = 1'b0;
      idleInputs();
      modelReset();

      vecs[0]  = '{2'b01, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd0, 16'h0001, 1'b0};
      vecs[1]  = '{2'b01, 1'b1, 16'hBEEF, 1'b0, 2'd0, 16'h0000, 2'd0, 16'h0002, 1'b0};
      vecs[2]  = '{2'b11, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd0, 16'h0001, 1'b0};
      vecs[3]  = '{2'b10, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd0, 16'h0001, 1'b0};
      vecs[4]  = '{2'b00, 1'b1, 16'h1234, 1'b0, 2'd0, 16'h0000, 2'd0, 16'h0001, 1'b0};
      vecs[5]  = '{2'b11, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd1, 16'h0002, 1'b0};
      vecs[6]  = '{2'b11, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd0, 16'h4000, 1'b1};
      vecs[7]  = '{2'b00, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd2, 16'h0001, 1'b0};
      vecs[8]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 2'd0, 16'h4000, 2'd0, 16'h0000, 1'b0};
      vecs[9]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 2'd3, 16'hFFFF, 2'd3, 16'h0011, 1'b0};
      vecs[10] = '{2'b01, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd1, 16'h0002, 1'b0};
      vecs[11] = '{2'b00, 1'b0, 16'h0000, 1'b1, 2'd1, 16'h0000, 2'd1, 16'h0001, 1'b0};
      vecs[12] = '{2'b00, 1'b0, 16'h0000, 1'b1, 2'd2, 16'h0000, 2'd2, 16'h0000, 1'b0};
      vecs[13] = '{2'b01, 1'b0, 16'h0000, 1'b1, 2'd1, 16'h0000, 2'd1, 16'h0002, 1'b0};
      vecs[14] = '{2'b11, 1'b0, 16'h0000, 1'b1, 2'd0, 16'hC000, 2'd0, 16'h0001, 1'b0};

      // Reset state
      doReset();
      readReg(2'd0, 16'h0000, "rst_status");
      readReg(2'd1, 16'h0000, "rst_hwm");
      readReg(2'd2, 16'h0000, "rst_vcnt");
      readReg(2'd3, 16'h0011, "rst_cap");
      checkOutput("rst_trap", 16'(trap), 16'h0);
      io_sel = 1'b0; io_addr = 2'd1; #1;
      checkOutput("dout_unselected", io_dout, 16'h0000);

      // Vector table
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].d, vecs[i].we, vecs[i].wd, 1'b1, vecs[i].wa, vecs[i].wr, vecs[i].wdat);
         checkOutput($sformatf("vec%0d_trap", i), 16'(trap), 16'(vecs[i].expTrap));
         readReg(vecs[i].ra, vecs[i].expRd, $sformatf("vec%0d_rd", i));
      end

      // Fill to capacity, then overflow
      doReset();
      push(17);
      readReg(2'd0, 16'h0011, "full_status");
      readReg(2'd1, 16'h0011, "full_hwm");
      readReg(2'd3, 16'h0011, "full_cap");
      push(1);
      checkOutput("ovf_trap", 16'(trap), 16'h1);
      readReg(2'd0, 16'h8011, "ovf_status");
      readReg(2'd2, 16'h0001, "ovf_vcnt");
      applyStimulus(2'b00, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 16'h0);
      checkOutput("trap_one_cycle", 16'(trap), 16'h0);

      // Clear racing a new overflow, then a clean clear
      applyStimulus(2'b01, 1'b0, 16'h0, 1'b1, 2'd0, 1'b1, 16'h8000);
      readReg(2'd0, 16'h8011, "ovf_set_wins");
      readReg(2'd2, 16'h0002, "ovf_vcnt2");
      ioWrite(2'd0, 16'h8000);
      readReg(2'd0, 16'h0011, "ovf_cleared");

      // Drain, underflow, saturate
      pop(17);
      pop(1);
      readReg(2'd0, 16'h4000, "unf_status");
      readReg(2'd2, 16'h0003, "unf_vcnt");
      pop(300);
      readReg(2'd2, 16'h00FF, "vcnt_sat");
      readReg(2'd0, 16'h4000, "unf_depth0");
      ioWrite(2'd2, 16'h0000);
      readReg(2'd2, 16'h0000, "vcnt_clear");

      // High-water reload and asynchronous reset mid-sequence
      doReset();
      push(5);
      pop(3);
      readReg(2'd1, 16'h0005, "hwm_peak");
      ioWrite(2'd1, 16'h0000);
      readReg(2'd1, 16'h0002, "hwm_reload");
      push(2);
      pop(1);
      @(negedge clk);
      resetq = 1'b0;
      modelReset();
      readReg(2'd0, 16'h0000, "async_status");
      readReg(2'd1, 16'h0000, "async_hwm");
      readReg(2'd2, 16'h0000, "async_vcnt");
      @(negedge clk);
      resetq = 1'b1;

      // Random walk against the model, alternating push-heavy and pop-heavy phases
      doReset();
      for (int i = 0; i < 3000; i++) begin
         int p;
         logic [1:0] d;
         logic sel;
         p = int'($urandom_range(0, 99));
         if (((i / 150) % 2) == 0) d = (p < 60) ? 2'b01 : (p < 80) ? 2'b11 : (p < 90) ? 2'b00 : 2'b10;
         else                      d = (p < 60) ? 2'b11 : (p < 80) ? 2'b01 : (p < 90) ? 2'b10 : 2'b00;
         sel = 1'($urandom_range(0, 1));
         applyStimulus(d, 1'($urandom_range(0, 1)), 16'($urandom), sel,
                       2'($urandom_range(0, 3)), sel && ($urandom_range(0, 7) == 0), 16'($urandom));
      end
      for (int a = 0; a < 4; a++) readReg(2'(a), expRead(1'b1, 2'(a)), $sformatf("rand_final%0d", a));

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end

endmodule
